data_memory_ctrl: RTL and testbench
===================================

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL have parameters: NB_DATA, 32, data/address width; NB_ADDR, 8, word-index width (2^NB_ADDR words).
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  access request valid.
- i_we  in  1  1 = store, 0 = load.
- i_width  in  2  00 byte, 01 half, 10 word.
- i_sign_flag  in  1  1 = sign-extend load, 0 = zero-extend.
- i_addr  in  NB_DATA  byte address.
- i_wdata  in  NB_DATA  store data, right-aligned.
- i_halt  in  1  requests memory dump.
- o_rdata  out  NB_DATA  extended load data.
- o_rvalid  out  1  load-data strobe.
- o_misalign  out  1  access-error strobe.
- o_busy  out  1  dump in progress.
- o_dump_data  out  NB_DATA  dumped word.
- o_dump_valid  out  1  dump word valid.
- i_dump_ready  in  1  dump sink ready.
- o_dump_done  out  1  dump complete.
REQ-003 SHALL use one clock and an asynchronous active-high reset, as already decided.

Function
REQ-004 SHALL form the word index from i_addr[NB_ADDR+1:2] and the byte lane from i_addr[1:0]; upper address bits are ignored.
REQ-005 SHALL treat an access as misaligned when: half with i_addr[0]=1; word with i_addr[1:0]!=0; or i_width=11.
REQ-006 SHALL, on a clock edge with i_req=1, i_we=1, aligned and IDLE, update only the addressed lanes:
- byte: lane = wdata[7:0].
- half: lanes {addr[1],1} / {addr[1],0} = wdata[15:0].
- word: all lanes.
REQ-007 SHALL register a load 1 cycle after i_req=1, i_we=0, aligned: o_rvalid=1 for one cycle, o_rdata = addressed byte or half, extended per i_sign_flag, or the full word.
REQ-008 SHALL return the newly written data for a load in the cycle immediately after a store to the same word.
REQ-009 SHALL, on a misaligned request, perform no write, pulse o_misalign one cycle later, and hold o_rvalid=0 with o_rdata=0.
REQ-010 SHALL hold o_rvalid=0 and o_rdata at its previous value in cycles without a valid load.
REQ-011 SHALL implement the dump FSM:
- IDLE->READ when i_halt=1, index=0.
- READ->SEND after one cycle, word latched into o_dump_data.
- SEND holds o_dump_valid=1 and data stable until i_dump_ready=1; on handshake, if index=2^NB_ADDR-1 ->DONE, else index+1 ->READ.
- DONE holds o_dump_done=1 until i_halt=0, then ->IDLE.
REQ-012 SHALL assert o_busy in every non-IDLE state and ignore i_req (no write, no rvalid, no misalign) while busy.
REQ-013 SHALL let i_halt deasserting mid-dump have no effect until DONE.

Reset
REQ-014 SHALL, on reset, drive all outputs to 0, set the FSM to IDLE and the dump index to 0, including when reset occurs mid-dump.
REQ-015 SHALL leave memory contents unaffected by reset.

Configuration
REQ-016 SHALL compile the dump FSM only when DMEM_DEBUG_DUMP_EN is defined.
REQ-017 SHALL, without DMEM_DEBUG_DUMP_EN, keep all dump ports present, tie o_busy, o_dump_valid, o_dump_done and o_dump_data to 0, and ignore i_halt and i_dump_ready.

Structure
REQ-018 SHALL take the width encodings (WIDTH_BYTE=00, WIDTH_HALF=01, WIDTH_WORD=10) and the FSM state encodings from a shared package, mips_mem_pkg.
REQ-019 SHALL instantiate one sub-module, dmem_byte_ram, holding the storage with 4 byte-write enables, one write port and one combinational read port.

Verification
REQ-020 Store word 0x80FF7F01 @0x10, then LB signed @0x12 -> o_rdata=0xFFFFFFFF, o_rvalid=1 one cycle after request.
REQ-021 Same memory, LHU @0x12 -> 0x000080FF; LH @0x10 -> 0x00007F01; LB @0x13 -> 0xFFFFFF80.
REQ-022 SB 0xAA @0x21 over word 0x11223344 @0x20, then LW @0x20 -> 0x1122AA44.
REQ-023 SW @0x06, then LH @0x03 -> o_misalign pulses twice, no write, o_rvalid=0, memory unchanged.
REQ-024 With DMEM_DEBUG_DUMP_EN defined and NB_ADDR=2: i_halt=1, i_dump_ready toggling -> exactly 4 handshakes with words 0..3 in order, then o_dump_done=1; i_req during the dump is ignored.
REQ-025 Reset asserted in SEND of word 2 -> all outputs 0 asynchronously, FSM IDLE; memory still returns prior data on LW.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_mem_pkg: shared access-width and dump-FSM encodings for the data mem. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mips_mem_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_READ = 2'd1,
        DUMP_SEND = 2'd2,
        DUMP_DONE = 2'd3
    } dump_state_t;

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
        logic bad;
        bad = 1'b1;
        case (width)
            WIDTH_BYTE: bad = 1'b0;
            WIDTH_HALF: bad = lane[0];
            WIDTH_WORD: bad = (lane != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_byte_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_byte_ram: word-organised RAM with 4 byte-lane write enables,           |
// | one synchronous write port and one combinational read port. Rev 1.0        |
// +----------------------------------------------------------------------------+
module dmem_byte_ram #(
    parameter int NB_LANE = 8,
    parameter int NB_ADDR = 8
) (
    input  logic                   clk,
    input  logic [3:0]             we,
    input  logic [NB_ADDR-1:0]     waddr,
    input  logic [4*NB_LANE-1:0]   wdata,
    input  logic [NB_ADDR-1:0]     raddr,
    output logic [4*NB_LANE-1:0]   rdata
);

    // No reset: contents survive a controller reset.
    logic [4*NB_LANE-1:0] r_mem [2**NB_ADDR];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                r_mem[waddr][i*NB_LANE +: NB_LANE] <= wdata[i*NB_LANE +: NB_LANE];
            end
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_memory_ctrl: byte/half/word data memory with extended loads and an    |
// | optional debug dump engine (define DMEM_DEBUG_DUMP_EN). Rev 1.0            |
// +----------------------------------------------------------------------------+
module data_memory_ctrl
    import mips_mem_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_req,
    input  logic               i_we,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [NB_DATA-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic               i_halt,
    output logic [NB_DATA-1:0] o_rdata,
    output logic               o_rvalid,
    output logic               o_misalign,
    output logic               o_busy,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_valid,
    input  logic               i_dump_ready,
    output logic               o_dump_done
);

    localparam int NB_LANE = NB_DATA / 4;

    logic [NB_ADDR-1:0] w_word_idx;
    logic [1:0]         w_lane;
    logic               w_misalign;
    logic               w_busy;
    logic               w_accept;
    logic               w_wr_en;
    logic [3:0]         w_be;
    logic [NB_DATA-1:0] w_wr_data;
    logic [NB_DATA-1:0] w_rd_word;
    logic [NB_DATA-1:0] w_load_data;
    logic [NB_ADDR-1:0] w_rd_addr;
    logic [NB_LANE-1:0]   w_byte;
    logic [2*NB_LANE-1:0] w_half;
    logic               unused_addr_hi;

    assign w_word_idx     = i_addr[NB_ADDR+1:2];
    assign w_lane         = i_addr[1:0];
    assign unused_addr_hi = ^i_addr[NB_DATA-1:NB_ADDR+2];
    assign w_misalign     = is_misaligned(i_width, w_lane);
    assign w_accept       = i_req & ~w_busy;
    assign w_wr_en        = w_accept & i_we & ~w_misalign;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be      = 4'b0000;
        w_wr_data = i_wdata;
        case (i_width)
            WIDTH_BYTE: begin
                w_be      = 4'b0001 << w_lane;
                w_wr_data = {4{i_wdata[NB_LANE-1:0]}};
            end
            WIDTH_HALF: begin
                w_be      = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wr_data = {2{i_wdata[2*NB_LANE-1:0]}};
            end
            WIDTH_WORD: w_be = 4'b1111;
            default:    w_be = 4'b0000;
        endcase
        if (!w_wr_en) begin
            w_be = 4'b0000;
        end
    end

    dmem_byte_ram #(
        .NB_LANE (NB_LANE),
        .NB_ADDR (NB_ADDR)
    ) u_ram (
        .clk   (clk),
        .we    (w_be),
        .waddr (w_word_idx),
        .wdata (w_wr_data),
        .raddr (w_rd_addr),
        .rdata (w_rd_word)
    );

    always_comb begin
        w_byte = w_rd_word[NB_LANE-1:0];
        case (w_lane)
            2'd1:    w_byte = w_rd_word[2*NB_LANE-1:NB_LANE];
            2'd2:    w_byte = w_rd_word[3*NB_LANE-1:2*NB_LANE];
            2'd3:    w_byte = w_rd_word[4*NB_LANE-1:3*NB_LANE];
            default: w_byte = w_rd_word[NB_LANE-1:0];
        endcase
        w_half = i_addr[1] ? w_rd_word[NB_DATA-1:2*NB_LANE] : w_rd_word[2*NB_LANE-1:0];

        w_load_data = w_rd_word;
        case (i_width)
            WIDTH_BYTE: w_load_data = {{(NB_DATA-NB_LANE){i_sign_flag & w_byte[NB_LANE-1]}}, w_byte};
            WIDTH_HALF: w_load_data = {{(NB_DATA-2*NB_LANE){i_sign_flag & w_half[2*NB_LANE-1]}}, w_half};
            default:    w_load_data = w_rd_word;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata    <= '0;
            o_rvalid   <= 1'b0;
            o_misalign <= 1'b0;
        end else begin
            o_rvalid   <= w_accept & ~i_we & ~w_misalign;
            o_misalign <= w_accept & w_misalign;
            if (w_accept & w_misalign) begin
                o_rdata <= '0;
            end else if (w_accept & ~i_we) begin
                o_rdata <= w_load_data;
            end
        end
    end

`ifdef DMEM_DEBUG_DUMP_EN
    dump_state_t        r_state;
    dump_state_t        w_state_nxt;
    logic [NB_ADDR-1:0] r_dump_idx;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= DUMP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_dump_idx  <= '0;
            o_dump_data <= '0;
        end else begin
            case (r_state)
                DUMP_IDLE: if (i_halt) r_dump_idx <= '0;
                DUMP_READ: o_dump_data <= w_rd_word;
                DUMP_SEND: if (i_dump_ready && (r_dump_idx != '1)) r_dump_idx <= r_dump_idx + 1'b1;
                default:   ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_busy       = 1'b1;
        o_dump_valid = 1'b0;
        o_dump_done  = 1'b0;
        case (r_state)
            DUMP_IDLE: begin
                o_busy = 1'b0;
                if (i_halt) w_state_nxt = DUMP_READ;
            end
            DUMP_READ: w_state_nxt = DUMP_SEND;
            DUMP_SEND: begin
                o_dump_valid = 1'b1;
                if (i_dump_ready) w_state_nxt = (r_dump_idx == '1) ? DUMP_DONE : DUMP_READ;
            end
            DUMP_DONE: begin
                o_dump_done = 1'b1;
                if (!i_halt) w_state_nxt = DUMP_IDLE;
            end
            default: w_state_nxt = DUMP_IDLE;
        endcase
    end

    assign w_busy    = o_busy;
    assign w_rd_addr = w_busy ? r_dump_idx : w_word_idx;
`else
    logic unused_dump;

    assign unused_dump  = i_halt ^ i_dump_ready;
    assign w_busy       = 1'b0;
    assign o_busy       = 1'b0;
    assign o_dump_valid = 1'b0;
    assign o_dump_done  = 1'b0;
    assign o_dump_data  = '0;
    assign w_rd_addr    = w_word_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_memory_ctrl: vector table, random ops vs byte-array model, reset   |
// | and dump (or dump tie-off) sequences. Rev 1.0                              |
// +----------------------------------------------------------------------------+
module tb_data_memory_ctrl;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 4;
    localparam int NWORDS  = 2**NB_ADDR;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_req;
    logic              i_we;
    logic [1:0]        i_width;
    logic              i_sign_flag;
    logic [31:0]       i_addr;
    logic [31:0]       i_wdata;
    logic              i_halt;
    logic [31:0]       o_rdata;
    logic              o_rvalid;
    logic              o_misalign;
    logic              o_busy;
    logic [31:0]       o_dump_data;
    logic              o_dump_valid;
    logic              i_dump_ready;
    logic              o_dump_done;

    int errors = 0;
    int checks = 0;

    data_memory_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_width      (i_width),
        .i_sign_flag  (i_sign_flag),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_halt       (i_halt),
        .o_rdata      (o_rdata),
        .o_rvalid     (o_rvalid),
        .o_misalign   (o_misalign),
        .o_busy       (o_busy),
        .o_dump_data  (o_dump_data),
        .o_dump_valid (o_dump_valid),
        .i_dump_ready (i_dump_ready),
        .o_dump_done  (o_dump_done)
    );

    always #5 clk = ~clk;

    // Behavioural model: flat byte array, little-endian, 4 bytes per word.
    logic [7:0]  mem_m [4*NWORDS];
    logic [31:0] exp_rdata = 32'h0;

    typedef struct {
        logic        req;
        logic        we;
        logic [1:0]  w;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rv;
        logic        mis;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic req, input logic we, input logic [1:0] w, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic rv, input logic mis, input logic [31:0] rd);
        vec_t v;
        v.req = req; v.we = we; v.w = w; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.rv = rv; v.mis = mis; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input int idx);
        return {mem_m[4*idx+3], mem_m[4*idx+2], mem_m[4*idx+1], mem_m[4*idx]};
    endfunction

    // One access as the rules describe it; returns expected strobes and updates exp_rdata.
    task automatic model_step(input logic req, input logic we, input logic [1:0] w, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic rv, output logic mis);
        int a;
        int n;
        longint val;
        bit bad;
        rv  = 1'b0;
        mis = 1'b0;
        if (!req) return;
        a   = int'(addr % (4 * NWORDS));
        bad = (w == 2'd3) || (w == 2'd1 && (a % 2) != 0) || (w == 2'd2 && (a % 4) != 0);
        if (bad) begin
            mis = 1'b1;
            exp_rdata = 32'h0;
            return;
        end
        n = 1 << w;
        if (we) begin
            for (int k = 0; k < n; k++) mem_m[a+k] = wdata[8*k +: 8];
        end else begin
            val = 0;
            for (int k = 0; k < n; k++) val = val + (longint'(mem_m[a+k]) << (8*k));
            if (sgn && n < 4 && mem_m[a+n-1][7]) val = val - (longint'(1) << (8*n));
            exp_rdata = val[31:0];
            rv = 1'b1;
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [1:0] w, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        i_req = req; i_we = we; i_width = w; i_sign_flag = sgn; i_addr = addr; i_wdata = wdata;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op(input logic req, input logic we, input logic [1:0] w, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        logic rv;
        logic mis;
        drive(req, we, w, sgn, addr, wdata);
        model_step(req, we, w, sgn, addr, wdata, rv, mis);
        step();
        check({tag, "_rvalid"}, {31'b0, o_rvalid}, {31'b0, rv});
        check({tag, "_misalign"}, {31'b0, o_misalign}, {31'b0, mis});
        check({tag, "_rdata"}, o_rdata, exp_rdata);
        i_req = 1'b0;
    endtask

    initial begin : main
        logic rv;
        logic mis;
        int   hs;
        int   cyc;
        i_rst = 1'b1; i_halt = 1'b0; i_dump_ready = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #12;
        check("reset_rdata", o_rdata, 32'h0);
        check("reset_flags", {27'b0, o_rvalid, o_misalign, o_busy, o_dump_valid, o_dump_done}, 32'h0);
        check("reset_dump_data", o_dump_data, 32'h0);
        @(negedge clk);
        i_rst = 1'b0;
        step();

        // Directed vectors: req, we, width, sign, addr, wdata, rvalid, misalign, rdata
        tbl.push_back(mk(1, 1, 2'b10, 0, 32'h04, 32'h01020304, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 2'b10, 0, 32'h10, 32'h80FF7F01, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 2'b00, 1, 32'h12, 32'h0,        1, 0, 32'hFFFFFFFF));
        tbl.push_back(mk(1, 0, 2'b01, 0, 32'h12, 32'h0,        1, 0, 32'h000080FF));
        tbl.push_back(mk(1, 0, 2'b01, 1, 32'h10, 32'h0,        1, 0, 32'h00007F01));
        tbl.push_back(mk(1, 0, 2'b00, 1, 32'h13, 32'h0,        1, 0, 32'hFFFFFF80));
        tbl.push_back(mk(1, 0, 2'b00, 0, 32'h13, 32'h0,        1, 0, 32'h00000080));
        tbl.push_back(mk(1, 1, 2'b10, 0, 32'h20, 32'h11223344, 0, 0, 32'h00000080));
        tbl.push_back(mk(1, 1, 2'b00, 0, 32'h21, 32'h123456AA, 0, 0, 32'h00000080));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h20, 32'h0,        1, 0, 32'h1122AA44));
        tbl.push_back(mk(1, 1, 2'b01, 0, 32'h22, 32'h5555BEEF, 0, 0, 32'h1122AA44));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h20, 32'h0,        1, 0, 32'hBEEFAA44));
        tbl.push_back(mk(1, 0, 2'b01, 1, 32'h22, 32'h0,        1, 0, 32'hFFFFBEEF));
        tbl.push_back(mk(1, 1, 2'b10, 0, 32'h06, 32'hDEADBEEF, 0, 1, 32'h0));
        tbl.push_back(mk(1, 0, 2'b01, 1, 32'h03, 32'h0,        0, 1, 32'h0));
        tbl.push_back(mk(0, 0, 2'b10, 0, 32'h04, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h04, 32'h0,        1, 0, 32'h01020304));
        tbl.push_back(mk(1, 0, 2'b11, 0, 32'h04, 32'h0,        0, 1, 32'h0));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h04, 32'h0,        1, 0, 32'h01020304));
        tbl.push_back(mk(1, 1, 2'b10, 0, 32'h48, 32'hCAFEF00D, 0, 0, 32'h01020304));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h08, 32'h0,        1, 0, 32'hCAFEF00D));
        tbl.push_back(mk(1, 0, 2'b00, 0, 32'h0B, 32'h0,        1, 0, 32'h000000CA));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].req, tbl[i].we, tbl[i].w, tbl[i].sgn, tbl[i].addr, tbl[i].wdata);
            model_step(tbl[i].req, tbl[i].we, tbl[i].w, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, rv, mis);
            step();
            check($sformatf("vec%0d_rvalid", i), {31'b0, o_rvalid}, {31'b0, tbl[i].rv});
            check($sformatf("vec%0d_misalign", i), {31'b0, o_misalign}, {31'b0, tbl[i].mis});
            check($sformatf("vec%0d_rdata", i), o_rdata, tbl[i].rd);
        end
        exp_rdata = tbl[tbl.size()-1].rd;

        // Fill every word so random loads never touch uninitialised storage.
        for (int i = 0; i < NWORDS; i++) begin
            rand_op(1'b1, 1'b1, 2'b10, 1'b0, {$urandom_range(0, 255), 24'h0} | 32'(4*i) | 32'h100, $urandom, "init");
        end
        for (int i = 0; i < 400; i++) begin
            rand_op(($urandom_range(0, 9) != 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 1), $urandom, $urandom, "rand");
        end

        // Asynchronous reset mid-cycle right after a load.
        rand_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, "pre_rst");
        #2 i_rst = 1'b1;
        #1;
        check("async_rst_rdata", o_rdata, 32'h0);
        check("async_rst_rvalid", {31'b0, o_rvalid}, 32'h0);
        exp_rdata = 32'h0;
        @(negedge clk);
        i_rst = 1'b0;
        step();
        rand_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, "post_rst_mem");

`ifdef DMEM_DEBUG_DUMP_EN
        // Full dump with random back-pressure and ignored requests.
        i_halt = 1'b1;
        step();
        hs = 0;
        cyc = 0;
        while (!o_dump_done && cyc < 2000) begin
            i_dump_ready = 1'($urandom_range(0, 1));
            drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, $urandom, $urandom);
            if (o_dump_valid && i_dump_ready) begin
                check($sformatf("dump_word%0d", hs), o_dump_data, model_word(hs));
                hs++;
            end
            step();
            check("dump_busy_rvalid", {31'b0, o_rvalid}, 32'h0);
            check("dump_busy_misalign", {31'b0, o_misalign}, 32'h0);
            i_halt = !(cyc >= 5 && cyc < 9);
            cyc++;
        end
        i_req = 1'b0;
        check("dump_handshakes", 32'(hs), 32'(NWORDS));
        check("dump_done", {31'b0, o_dump_done}, 32'h1);
        step();
        step();
        check("dump_done_hold", {30'b0, o_dump_done, o_busy}, 32'h3);
        i_halt = 1'b0;
        step();
        check("dump_exit", {29'b0, o_dump_done, o_busy, o_dump_valid}, 32'h0);
        rand_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, "after_dump_w0");

        // Reset while presenting word 2.
        i_halt = 1'b1;
        i_dump_ready = 1'b1;
        hs = 0;
        cyc = 0;
        while (!(hs == 2 && o_dump_valid) && cyc < 200) begin
            if (o_dump_valid && i_dump_ready) hs++;
            step();
            cyc++;
        end
        check("reach_send2", {31'b0, o_dump_valid}, 32'h1);
        check("send2_data", o_dump_data, model_word(2));
        i_dump_ready = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check("rst_send_flags", {27'b0, o_rvalid, o_misalign, o_busy, o_dump_valid, o_dump_done}, 32'h0);
        check("rst_send_dump_data", o_dump_data, 32'h0);
        check("rst_send_rdata", o_rdata, 32'h0);
        exp_rdata = 32'h0;
        i_halt = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        step();
        check("rst_send_idle", {31'b0, o_busy}, 32'h0);
        rand_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, "rst_send_mem");
`else
        // Dump engine absent: halt and ready are ignored and accesses proceed.
        i_halt = 1'b1;
        i_dump_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_op(1'b1, 1'(i % 2), 2'b10, 1'b0, 32'(4 * i), $urandom, "halt_ignored");
            check("tieoff_flags", {29'b0, o_busy, o_dump_valid, o_dump_done}, 32'h0);
            check("tieoff_data", o_dump_data, 32'h0);
        end
        i_halt = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
